apu_div_queue: RTL and testbench

APU_DIV_QUEUE -- requirements
Module: apu_div_queue

---
 rtl/apu_div_queue_pkg.sv | 45 ++++
 rtl/apu_req_fifo.sv | 61 ++++++
 rtl/apu_div_queue.sv | 159 +++++++++++++++
 tb/tb_apu_div_queue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_div_queue_pkg.sv
// Shared constants, funct codes and state types for the
// queued radix-2 divide unit.
package apu_div_queue_pkg;

  localparam int DIV_DATA_WIDTH    = 32;
  localparam int DIV_REG_SEL_WIDTH = 5;
  localparam int DIV_QUEUE_DEPTH   = 2;
  localparam int FUNCT_W           = 10;

  // {funct7, funct3} of the RV32M divide group
  localparam logic [9:0] FUNCT_DIV  = 10'b0000001_100;
  localparam logic [9:0] FUNCT_DIVU = 10'b0000001_101;
  localparam logic [9:0] FUNCT_REM  = 10'b0000001_110;
  localparam logic [9:0] FUNCT_REMU = 10'b0000001_111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } div_state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_DIVU,
    OP_REMU,
    OP_DIV,
    OP_REM
  } div_op_t;

  function automatic div_op_t decode_op(
    input logic [9:0] f
  );
    div_op_t op;
    op = OP_NONE;
    unique case (1'b1)
      (f == FUNCT_DIVU): op = OP_DIVU;
      (f == FUNCT_REMU): op = OP_REMU;
      (f == FUNCT_DIV):  op = OP_DIV;
      (f == FUNCT_REM):  op = OP_REM;
      default:           op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/apu_req_fifo.sv
// Circular request buffer with a registered full flag;
// push and pop may coincide on one edge.
module apu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (cnt == '0);
  assign rdata   = mem[rptr];

  always_comb begin
    cnt_d = cnt;
    if (do_push & ~do_pop)
      cnt_d = cnt + 1'b1;
    else if (do_pop & ~do_push)
      cnt_d = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      end
      if (do_pop)
        rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      cnt  <= cnt_d;
      full <= (cnt_d == FULL_CNT);
    end
  end

endmodule

// File: rtl/apu_div_queue.sv
// Queued restoring divider: one quotient bit per cycle,
// results written back through a one-cycle strobe.
module apu_div_queue
  import apu_div_queue_pkg::*;
#(
  parameter int DATA_WIDTH    = DIV_DATA_WIDTH,
  parameter int REG_SEL_WIDTH = DIV_REG_SEL_WIDTH,
  parameter int QUEUE_DEPTH   = DIV_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [DATA_WIDTH-1:0]    rs1,
  input  logic [DATA_WIDTH-1:0]    rs2,
  input  logic [REG_SEL_WIDTH-1:0] rd_sel,
  input  logic [9:0]               funct,
  output logic                     busy,
  output logic                     apu_wr_req,
  output logic [REG_SEL_WIDTH-1:0] apu_wr_sel,
  output logic [DATA_WIDTH-1:0]    apu_wr_data
);

  localparam int W    = DATA_WIDTH;
  localparam int SW   = REG_SEL_WIDTH;
  localparam int FW   = 2 * W + SW + FUNCT_W;
  localparam int CNTW = $clog2(W);
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(W - 1);

  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [FW-1:0]      head;
  logic [W-1:0]       h_rs1;
  logic [W-1:0]       h_rs2;
  logic [SW-1:0]      h_sel;
  logic [FUNCT_W-1:0] h_funct;

  assign push = req & ~fifo_full;
  assign busy = fifo_full;
  assign {h_rs1, h_rs2, h_sel, h_funct} = head;

  apu_req_fifo #(
    .WIDTH (FW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({rs1, rs2, rd_sel, funct}),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  div_state_t    state;
  div_state_t    state_d;
  logic [CNTW-1:0] step;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  dvs_q;
  logic [SW-1:0] sel_q;
  div_op_t       op_q;
  logic          neg_q;
  logic          neg_r;
  logic          dz_q;

  assign pop = (state == S_IDLE) & ~fifo_empty;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (!fifo_empty) state_d = S_CALC;
      S_CALC: if (step == LAST_STEP) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Signed ops divide magnitudes; signs are reapplied at DONE
  div_op_t      h_op;
  logic         h_sgn;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;

  assign h_op  = decode_op(h_funct);
  assign h_sgn = (h_op == OP_DIV) | (h_op == OP_REM);
  assign a_neg = h_sgn & h_rs1[W-1];
  assign b_neg = h_sgn & h_rs2[W-1];
  assign a_mag = a_neg ? -h_rs1 : h_rs1;
  assign b_mag = b_neg ? -h_rs2 : h_rs2;

  logic [W:0] rem_sh;
  logic [W:0] diff;
  logic       ge;

  assign rem_sh = {rem_q, quo_q[W-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign ge     = ~diff[W];

  logic [W-1:0] q_res;
  logic [W-1:0] r_res;
  logic [W-1:0] result;

  // Zero divisor keeps all-ones quotient regardless of signs
  assign q_res = dz_q ? '1 : (neg_q ? -quo_q : quo_q);
  assign r_res = neg_r ? -rem_q : rem_q;

  always_comb begin
    result = '0;
    case (op_q)
      OP_DIVU, OP_DIV: result = q_res;
      OP_REMU, OP_REM: result = r_res;
      default:         result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      sel_q       <= '0;
      op_q        <= OP_NONE;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_q        <= 1'b0;
      apu_wr_req  <= 1'b0;
      apu_wr_sel  <= '0;
      apu_wr_data <= '0;
    end else begin
      state       <= state_d;
      apu_wr_req  <= (state == S_DONE) && (sel_q != '0);
      apu_wr_sel  <= (state == S_DONE) ? sel_q : '0;
      apu_wr_data <= (state == S_DONE) ? result : '0;
      if (pop) begin
        step  <= '0;
        quo_q <= a_mag;
        rem_q <= '0;
        dvs_q <= b_mag;
        sel_q <= h_sel;
        op_q  <= h_op;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dz_q  <= (h_rs2 == '0);
      end else if (state == S_CALC) begin
        step  <= step + 1'b1;
        quo_q <= {quo_q[W-2:0], ge};
        rem_q <= ge ? diff[W-1:0] : rem_sh[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_apu_div_queue.sv
// Directed and randomized checks of the queued divider
// against an arithmetic reference model.
module tb_apu_div_queue;
  import apu_div_queue_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [W-1:0]  rs1 = '0;
  logic [W-1:0]  rs2 = '0;
  logic [SW-1:0] rd_sel = '0;
  logic [9:0]    funct = '0;
  logic          busy;
  logic          apu_wr_req;
  logic [SW-1:0] apu_wr_sel;
  logic [W-1:0]  apu_wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit busy_seen = 1'b0;

  typedef struct {
    int            c;
    logic [SW-1:0] s;
    logic [W-1:0]  d;
  } wb_t;

  wb_t wb_q[$];

  typedef struct {
    logic [SW-1:0] s;
    logic [W-1:0]  d;
  } exp_t;

  exp_t exp_q[$];

  apu_div_queue #(
    .DATA_WIDTH    (W),
    .REG_SEL_WIDTH (SW),
    .QUEUE_DEPTH   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd_sel      (rd_sel),
    .funct       (funct),
    .busy        (busy),
    .apu_wr_req  (apu_wr_req),
    .apu_wr_sel  (apu_wr_sel),
    .apu_wr_data (apu_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (apu_wr_req)
      wb_q.push_back('{cyc, apu_wr_sel, apu_wr_data});
    if (busy)
      busy_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_div(
    input logic [9:0]   f,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic                ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (f == FUNCT_DIVU) return (b == 0) ? '1 : a / b;
    if (f == FUNCT_REMU) return (b == 0) ? a : a % b;
    if (f == FUNCT_DIV) begin
      if (b == 0) return '1;
      if (ovf) return a;
      return sa / sb;
    end
    if (f == FUNCT_REM) begin
      if (b == 0) return a;
      if (ovf) return '0;
      return sa % sb;
    end
    return '0;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(
    input  logic [9:0]    f,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [SW-1:0] s,
    output int            acc
  );
    int n;
    n = 0;
    @(negedge clk);
    req = 1'b1;
    funct = f;
    rs1 = a;
    rs2 = b;
    rd_sel = s;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300)
      chk("send_timeout", 64'(busy), 64'd0);
    acc = cyc + 1;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_wb(
    input string         tag,
    input logic [SW-1:0] es,
    input logic [W-1:0]  ed,
    input int            ec
  );
    int n;
    n = 0;
    while (wb_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_present"}, 64'(wb_q.size() != 0), 64'd1);
    if (wb_q.size() != 0) begin
      wb_t w;
      w = wb_q.pop_front();
      if (ec >= 0)
        chk({tag, "_cycle"}, 64'(w.c), 64'(ec));
      chk({tag, "_sel"}, 64'(w.s), 64'(es));
      chk({tag, "_data"}, 64'(w.d), 64'(ed));
    end
  endtask

  initial begin
    int a1, a2, a3, a4, t, t2;
    logic [9:0]    rf;
    logic [W-1:0]  ra, rb;
    logic [SW-1:0] rsel;
    logic [9:0]    fsel [5];

    fsel[0] = FUNCT_DIV;
    fsel[1] = FUNCT_DIVU;
    fsel[2] = FUNCT_REM;
    fsel[3] = FUNCT_REMU;
    fsel[4] = 10'h00B;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_req", 64'(apu_wr_req), 64'd0);
    chk("rst_wr_sel", 64'(apu_wr_sel), 64'd0);
    chk("rst_wr_data", 64'(apu_wr_data), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    busy_seen = 1'b0;
    send(FUNCT_DIVU, 32'd1234, 32'd53, 5'd11, a1);
    wait_wb("divu", 5'd11, 32'd23, a1 + 34);
    send(FUNCT_REMU, 32'd1234, 32'd53, 5'd11, t);
    wait_wb("remu", 5'd11, 32'd15, t + 34);
    chk("single_busy", 64'(busy_seen), 64'd0);

    send(FUNCT_DIV, 32'hFFFF_FB2E, 32'd53, 5'd12, t);
    wait_wb("div_neg", 5'd12, 32'hFFFF_FFE9, t + 34);
    send(FUNCT_REM, 32'hFFFF_FB2E, 32'd53, 5'd13, t);
    wait_wb("rem_neg", 5'd13, 32'hFFFF_FFF1, t + 34);

    send(FUNCT_DIVU, 32'd7, 32'd0, 5'd14, t);
    wait_wb("divu_dz", 5'd14, 32'hFFFF_FFFF, t + 34);
    send(FUNCT_REMU, 32'd7, 32'd0, 5'd15, t);
    wait_wb("remu_dz", 5'd15, 32'd7, t + 34);
    send(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, t);
    wait_wb("div_ovf", 5'd16, 32'h8000_0000, t + 34);
    send(FUNCT_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, t);
    wait_wb("rem_ovf", 5'd17, 32'd0, t + 34);
    send(FUNCT_DIV, 32'hFFFF_FFF9, 32'd0, 5'd18, t);
    wait_wb("div_dz_neg", 5'd18, 32'hFFFF_FFFF, t + 34);
    send(10'h3FF, 32'd99, 32'd3, 5'd19, t);
    wait_wb("bad_funct", 5'd19, 32'd0, t + 34);

    send(FUNCT_DIVU, 32'd1000, 32'd7, 5'd1, a1);
    send(FUNCT_REMU, 32'd1000, 32'd7, 5'd2, a2);
    send(FUNCT_DIV, 32'd100, 32'hFFFF_FFF9, 5'd3, a3);
    chk("bp_busy_high", 64'(busy), 64'd1);
    send(FUNCT_REM, 32'hFFFF_FF9C, 32'd7, 5'd4, a4);
    chk("bp_acc2", 64'(a2 - a1), 64'd1);
    chk("bp_acc3", 64'(a3 - a1), 64'd2);
    chk("bp_acc4", 64'(a4 - a1), 64'd36);
    wait_wb("bp1", 5'd1, 32'd142, a1 + 34);
    wait_wb("bp2", 5'd2, 32'd6, a1 + 68);
    wait_wb("bp3", 5'd3, 32'hFFFF_FFF2, a1 + 102);
    wait_wb("bp4", 5'd4, 32'hFFFF_FFFE, a1 + 136);

    send(FUNCT_DIVU, 32'd5000, 32'd3, 5'd6, t);
    send(FUNCT_DIVU, 32'd77, 32'd7, 5'd8, t2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    req = 1'b1;
    funct = FUNCT_DIVU;
    rs1 = 32'd50;
    rs2 = 32'd5;
    rd_sel = 5'd7;
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_wr_req", 64'(apu_wr_req), 64'd0);
    repeat (120) @(negedge clk);
    chk("mid_rst_no_wb", 64'(wb_q.size()), 64'd0);
    chk("mid_rst_busy_late", 64'(busy), 64'd0);
    wb_q.delete();
    send(FUNCT_DIVU, 32'd100, 32'd7, 5'd9, t);
    wait_wb("post_rst", 5'd9, 32'd14, t + 34);

    send(FUNCT_DIVU, 32'd9, 32'd3, 5'd0, t);
    send(FUNCT_DIVU, 32'd45, 32'd6, 5'd5, t2);
    wait_wb("x0_next", 5'd5, 32'd7, t + 68);

    for (int i = 0; i < 24; i++) begin
      rf = fsel[$urandom_range(0, 4)];
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = W'($urandom_range(0, 5000));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = '1;
        2: rb = W'($urandom_range(1, 40));
        3: rb = -W'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      rsel = SW'($urandom_range(0, 31));
      if (rsel != '0)
        exp_q.push_back('{rsel, ref_div(rf, ra, rb)});
      send(rf, ra, rb, rsel, t);
    end
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      wait_wb("rand", e.s, e.d, -1);
    end
    repeat (80) @(negedge clk);
    chk("rand_no_extra", 64'(wb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
